// File: rtl/sub_apb_stream_bridge.sv
// APB register slave that pushes DATA writes into a FIFO drained on a valid/ready stream.
// Optional macro SUB_APB_SLVERR_EN: pslverr on DATA write to a full FIFO and on reserved-address access.
module sub_apb_stream_bridge #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             psel,
  input  logic             penable,
  input  logic             pwrite,
  input  logic [AW-1:0]    paddr,
  input  logic [WIDTH-1:0] pwdata,
  output logic [WIDTH-1:0] prdata,
  output logic             pready,
  output logic             pslverr,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, SETUP, WAIT, DONE} state_t;
  state_t state;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr, rd_ptr, count;
  logic             empty, full, en, ovf, flush_pend;
  logic             commit, push, pop, serr;
  logic [1:0]       addr;
  logic [WIDTH-1:0] status, rdata;
  logic             unused_ok;

  assign addr      = paddr[3:2];
  assign unused_ok = ^{paddr, pwdata};
  assign count     = wr_ptr - rd_ptr;
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign m_valid   = !empty && en;
  assign m_data    = m_valid ? mem[rd_ptr[PW-1:0]] : '0;
  assign pop       = m_valid && m_ready;

  // Side effects land on the WAIT->DONE edge, so DONE presents their outcome.
  assign commit = (state == WAIT) && psel;
  assign push   = commit && pwrite && (addr == 2'd0) && !full;

`ifdef SUB_APB_SLVERR_EN
  assign serr = (addr == 2'd3) || (pwrite && (addr == 2'd0) && full);
`else
  assign serr = 1'b0;
`endif

  always_comb begin
    status         = '0;
    status[PW:0]   = count;
    status[5]      = empty;
    status[6]      = full;
    status[7]      = ovf;
    rdata          = '0;
    case (addr)
      2'd1:    rdata    = status;
      2'd2:    rdata[0] = en;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= pwdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pready     <= 1'b0;
      pslverr    <= 1'b0;
      prdata     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      en         <= 1'b1;
      ovf        <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      pready     <= 1'b0;
      pslverr    <= 1'b0;
      flush_pend <= 1'b0;
      case (state)
        IDLE:    if (psel && !penable) state <= SETUP;
        SETUP:   if (!psel) state <= IDLE; else if (penable) state <= WAIT;
        WAIT:    state <= psel ? DONE : IDLE;
        DONE:    state <= psel ? SETUP : IDLE;
        default: state <= IDLE;
      endcase
      if (commit) begin
        pready  <= 1'b1;
        pslverr <= serr;
        prdata  <= pwrite ? '0 : rdata;
        if (pwrite) begin
          case (addr)
            2'd0:    if (full) ovf <= 1'b1;
            2'd1:    if (pwdata[7]) ovf <= 1'b0;
            2'd2:    begin en <= pwdata[0]; flush_pend <= pwdata[1]; end
            default: ;
          endcase
        end
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      // Flush lands one cycle after the CTRL write completes and overrides any pop.
      if (flush_pend) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end
    end
  end
endmodule

// File: tb/tb_sub_apb_stream_bridge.sv
// Directed bench for sub_apb_stream_bridge: queue-based model plus per-cycle stream compare.
module tb_sub_apb_stream_bridge;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 4;
`ifdef SUB_APB_SLVERR_EN
  localparam bit SLV = 1'b1;
`else
  localparam bit SLV = 1'b0;
`endif

  logic             clk = 1'b0, rst = 1'b1;
  logic             psel = 1'b0, penable = 1'b0, pwrite = 1'b0, m_ready = 1'b0;
  logic [AW-1:0]    paddr = '0;
  logic [WIDTH-1:0] pwdata = '0;
  logic [WIDTH-1:0] prdata, m_data;
  logic             pready, pslverr, m_valid;

  sub_apb_stream_bridge #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Model: a word queue plus en/ovf flags; transfers are handed over by the APB task.
  logic [7:0] q[$];
  bit         en_m = 1'b1, ovf_m = 1'b0, flush_m = 1'b0;
  bit         tx_pend = 1'b0, tx_wr = 1'b0, exp_err = 1'b0;
  int         tx_addr = 0;
  logic [7:0] tx_data = '0, exp_rd = '0;

  always @(posedge clk) begin
    int n;
    bit pop, was_full;
    n        = q.size();
    pop      = en_m && (n > 0) && m_ready;
    was_full = (n == DEPTH);
    if (rst) begin
      q.delete();
      en_m = 1'b1; ovf_m = 1'b0; flush_m = 1'b0; tx_pend = 1'b0;
    end else begin
      if (tx_pend) begin
        exp_rd = '0;
        if (!tx_wr && tx_addr == 1) exp_rd = {ovf_m, was_full, n == 0, 5'(n)};
        if (!tx_wr && tx_addr == 2) exp_rd = {7'd0, en_m};
        exp_err = SLV && ((tx_addr == 3) || (tx_wr && tx_addr == 0 && was_full));
      end
      if (pop) void'(q.pop_front());
      if (flush_m) begin q.delete(); flush_m = 1'b0; end
      if (tx_pend) begin
        tx_pend = 1'b0;
        if (tx_wr) begin
          case (tx_addr)
            0: if (was_full) ovf_m = 1'b1; else q.push_back(tx_data);
            1: if (tx_data[7]) ovf_m = 1'b0;
            2: begin en_m = tx_data[0]; flush_m = tx_data[1]; end
            default: ;
          endcase
        end
      end
    end
  end

  logic [7:0] out_log[$];
  int         out_cyc[$];
  int         cyc = 0;

  always @(negedge clk) begin
    bit exp_v;
    cyc++;
    if (!rst) begin
      exp_v = en_m && (q.size() > 0);
      chk("m_valid", m_valid, exp_v);
      if (exp_v) chk("m_data", m_data, q[0]);
      if (m_valid && m_ready) begin
        out_log.push_back(m_data);
        out_cyc.push_back(cyc);
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the edge that ends DONE.
  task automatic apb(input bit wr, input int addr, input logic [7:0] data,
                     output logic [7:0] rd, output bit err);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = AW'(addr * 4); pwdata = data;
    @(negedge clk); chk("pready_c0", pready, 0);
    @(posedge clk); #1 penable = 1'b1;
    @(negedge clk); chk("pready_c1", pready, 0);
    @(posedge clk); #1;
    tx_wr = wr; tx_addr = addr; tx_data = data; tx_pend = 1'b1;
    @(negedge clk); chk("pready_c2", pready, 0);
    @(negedge clk); chk("pready_c3", pready, 1);
    if (!wr) chk("prdata", prdata, exp_rd);
    chk("pslverr", pslverr, exp_err);
    rd = prdata; err = pslverr;
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wr(input int addr, input logic [7:0] data);
    logic [7:0] d; bit e;
    apb(1'b1, addr, data, d, e);
  endtask

  task automatic rd(input int addr, output logic [7:0] d);
    bit e;
    apb(1'b0, addr, 8'h00, d, e);
  endtask

  task automatic apb_abort(input int addr, input logic [7:0] data);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = AW'(addr * 4); pwdata = data;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    repeat (3) begin @(negedge clk); chk("pready_abort", pready, 0); end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    bit e;
    logic [7:0] exp_w[$];

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_pready", pready, 0);
    chk("rst_pslverr", pslverr, 0);
    chk("rst_prdata", prdata, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    @(posedge clk); #1;
    rd(1, d); chk("status_reset", d, 8'h20);
    rd(2, d); chk("ctrl_reset", d, 8'h01);

    wr(0, 8'hA5);
    wr(0, 8'h3C);
    @(negedge clk);
    chk("head_valid", m_valid, 1);
    chk("head_data", m_data, 8'hA5);
    @(posedge clk); #1;
    rd(1, d); chk("status_two", d, 8'h02);

    out_log.delete(); out_cyc.delete();
    m_ready = 1'b1;
    idle(4);
    m_ready = 1'b0;
    chk("drain_cnt", out_log.size(), 2);
    if (out_log.size() == 2) begin
      chk("drain_w0", out_log[0], 8'hA5);
      chk("drain_w1", out_log[1], 8'h3C);
      chk("drain_consec", out_cyc[1] - out_cyc[0], 1);
    end
    rd(1, d); chk("status_drained", d, 8'h20);

    for (int i = 0; i < 9; i++) apb(1'b1, 0, 8'(i), d, e);
    chk("slverr_9th", e, SLV);
    rd(1, d); chk("status_full_ovf", d, 8'hC8);
    wr(1, 8'h80);
    rd(1, d); chk("status_ovf_clr", d, 8'h48);
    apb(1'b0, 3, 8'h00, d, e); chk("rsvd_read", d, 8'h00); chk("rsvd_err", e, SLV);

    wr(2, 8'h03);
    rd(1, d); chk("status_flush_full", d, 8'h20);

    wr(2, 8'h00);
    wr(0, 8'h11); wr(0, 8'h22); wr(0, 8'h33);
    out_log.delete(); out_cyc.delete();
    m_ready = 1'b1;
    idle(3);
    @(negedge clk); chk("en0_hold", m_valid, 0);
    chk("en0_no_pop", out_log.size(), 0);
    @(posedge clk); #1;
    wr(2, 8'h01);
    idle(5);
    m_ready = 1'b0;
    chk("en1_cnt", out_log.size(), 3);
    if (out_log.size() == 3) begin
      chk("en1_w0", out_log[0], 8'h11);
      chk("en1_w1", out_log[1], 8'h22);
      chk("en1_w2", out_log[2], 8'h33);
    end

    wr(0, 8'h44); wr(0, 8'h55);
    wr(2, 8'h03);
    @(negedge clk); chk("flush_valid", m_valid, 0);
    @(posedge clk); #1;
    rd(1, d); chk("status_flush", d, 8'h20);

    apb_abort(0, 8'h99);
    rd(1, d); chk("status_abort", d, 8'h20);

    out_log.delete(); out_cyc.delete();
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      exp_w.push_back(8'(i * 13 + 5));
      wr(0, 8'(i * 13 + 5));
    end
    idle(2);
    m_ready = 1'b0;
    chk("wrap_cnt", out_log.size(), 20);
    for (int i = 0; i < 20 && i < out_log.size(); i++) chk("wrap_word", out_log[i], exp_w[i]);
    rd(1, d); chk("status_wrap", d, 8'h20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
